// File: rtl/thermal_frame_sequencer_if.sv
// Bundles the sensor, scaler and framebuffer signals of thermal_frame_sequencer.
// slave is the sequencer's view; master is the view of the logic around it.
interface thermal_frame_sequencer_if #(
  parameter int unsigned pixel_width_p = 16,
  parameter int unsigned addr_width_p  = 19,
  parameter int unsigned cnt_width_p   = 8
);
  logic [pixel_width_p-1:0] pixel_i;
  logic                     valid_i;
  logic                     sof_i;
  logic [pixel_width_p-1:0] scl_pixel_o;
  logic                     scl_valid_o;
  logic                     scl_ready_i;
  logic                     scl_reset_o;
  logic [pixel_width_p-1:0] scl_out_pixel_i;
  logic                     scl_out_valid_i;
  logic                     scl_out_ready_o;
  logic [addr_width_p-1:0]  fb_addr_o;
  logic [pixel_width_p-1:0] fb_data_o;
  logic                     fb_we_o;
  logic                     fb_ready_i;
  logic                     frame_done_o;
  logic [cnt_width_p-1:0]   drop_cnt_o;
  logic [cnt_width_p-1:0]   err_cnt_o;

  modport slave (
    input  pixel_i, valid_i, sof_i, scl_ready_i, scl_out_pixel_i, scl_out_valid_i, fb_ready_i,
    output scl_pixel_o, scl_valid_o, scl_reset_o, scl_out_ready_o, fb_addr_o, fb_data_o,
           fb_we_o, frame_done_o, drop_cnt_o, err_cnt_o
  );

  modport master (
    output pixel_i, valid_i, sof_i, scl_ready_i, scl_out_pixel_i, scl_out_valid_i, fb_ready_i,
    input  scl_pixel_o, scl_valid_o, scl_reset_o, scl_out_ready_o, fb_addr_o, fb_data_o,
           fb_we_o, frame_done_o, drop_cnt_o, err_cnt_o
  );
endinterface

// File: rtl/thermal_frame_sequencer.sv
// Frame admission, abort/resync and framebuffer addressing around the 80x60->640x480 scaler.
// Optional FILL idle watchdog: define THERMAL_FRAME_SEQ_TIMEOUT_EN.
module thermal_frame_sequencer #(
  parameter int unsigned pixel_width_p   = 16,
  parameter int unsigned input_width_p   = 80,
  parameter int unsigned input_height_p  = 60,
  parameter int unsigned output_width_p  = 640,
  parameter int unsigned output_height_p = 480,
  parameter int unsigned timeout_p       = 65535,
  parameter int unsigned cnt_width_p     = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  thermal_frame_sequencer_if.slave  seq
);

  localparam int unsigned InPix  = input_width_p * input_height_p;
  localparam int unsigned OutPix = output_width_p * output_height_p;
  localparam int unsigned InW    = $clog2(InPix);
  localparam int unsigned AddrW  = $clog2(OutPix);
  localparam logic [InW-1:0]   InLast  = InW'(InPix - 1);
  localparam logic [AddrW-1:0] OutLast = AddrW'(OutPix - 1);

  if (InPix < 2 || OutPix < 2 || timeout_p < 1) begin : g_bad_cfg
    $error("thermal_frame_sequencer: frame sizes must exceed one pixel and timeout_p must be nonzero");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN,
    ST_ABORT
  } state_e;

  state_e                 state_q;
  logic [InW-1:0]         in_cnt_q;
  logic [AddrW-1:0]       out_cnt_q;
  logic [cnt_width_p-1:0] drop_cnt_q;
  logic [cnt_width_p-1:0] err_cnt_q;
  logic                   scl_reset_q;
  logic                   frame_done_q;

  logic sof_px, body_px, in_fill, fwd, fb_wr, timeout_hit, abort_req;

  function automatic logic [cnt_width_p-1:0] sat_inc(input logic [cnt_width_p-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign sof_px  = seq.valid_i & seq.sof_i;
  assign body_px = seq.valid_i & ~seq.sof_i;
  assign in_fill = (state_q == ST_FILL);

  // A FILL pixel only reaches the scaler when it cannot trigger an abort.
  assign fwd = ((state_q == ST_IDLE) & sof_px) | (in_fill & body_px & seq.scl_ready_i);

  assign fb_wr = (state_q == ST_DRAIN) & seq.scl_out_valid_i & seq.fb_ready_i;

`ifdef THERMAL_FRAME_SEQ_TIMEOUT_EN
  localparam int unsigned WdW = (timeout_p > 1) ? $clog2(timeout_p) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(timeout_p - 1);

  logic [WdW-1:0] wd_q;

  assign timeout_hit = in_fill & ~seq.valid_i & (wd_q == WdLast);

  always_ff @(posedge clk_i) begin
    if (reset_i || !in_fill || seq.valid_i || timeout_hit) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign abort_req = in_fill & ((seq.valid_i & (seq.sof_i | ~seq.scl_ready_i)) | timeout_hit);

  // NOTE: all state here updates with non-blocking assignments so every branch
  // sees the pre-edge values; blocking assignments would make results order-dependent.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      drop_cnt_q   <= '0;
      err_cnt_q    <= '0;
      scl_reset_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      scl_reset_q  <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sof_px) begin
            in_cnt_q <= InW'(1);
            state_q  <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (abort_req) begin
            err_cnt_q   <= sat_inc(err_cnt_q);
            scl_reset_q <= 1'b1;
            state_q     <= ST_ABORT;
          end else if (fwd) begin
            if (in_cnt_q == InLast) begin
              in_cnt_q <= '0;
              state_q  <= ST_DRAIN;
            end else begin
              in_cnt_q <= in_cnt_q + 1'b1;
            end
          end
        end
        ST_ABORT: begin
          in_cnt_q <= '0;
          state_q  <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (sof_px) begin
            drop_cnt_q <= sat_inc(drop_cnt_q);
          end
          if (fb_wr) begin
            if (out_cnt_q == OutLast) begin
              out_cnt_q    <= '0;
              frame_done_q <= 1'b1;
              state_q      <= ST_IDLE;
            end else begin
              out_cnt_q <= out_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign seq.scl_pixel_o     = seq.pixel_i;
  assign seq.scl_valid_o     = fwd;
  assign seq.scl_reset_o     = scl_reset_q;
  assign seq.scl_out_ready_o = (state_q == ST_DRAIN) & seq.fb_ready_i;
  assign seq.fb_addr_o       = out_cnt_q;
  assign seq.fb_data_o       = seq.scl_out_pixel_i;
  assign seq.fb_we_o         = fb_wr;
  assign seq.frame_done_o    = frame_done_q;
  assign seq.drop_cnt_o      = drop_cnt_q;
  assign seq.err_cnt_o       = err_cnt_q;

endmodule
